axi_sram_lat: RTL and testbench

Parametrised AXI4-Lite SRAM slave with on-chip storage, byte-strobed writes, programmable read/write latency and address-range error responses. Successor to the DPI-backed zero-latency memory model. It sits behind the core's IFU/LSU AXI masters (or the crossbar) so that multi-cycle memory behaviour can be exercised in simulation and synthesised for FPGA.

---
 rtl/axi_sram_pkg.sv | 22 ++
 rtl/axi_sram_lat_ram.sv | 42 ++++
 rtl/axi_sram_lat.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_sram_lat.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared definitions for the latency-programmable AXI4-Lite SRAM slave.
// Holds response codes, the FSM state encodings and the latency counter width.
package axi_sram_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/axi_sram_lat_ram.sv
// Word-organised storage with one synchronous read port and one byte-enabled write port.
// Only the read data register is reset; array contents are left untouched by reset.
module axi_sram_lat_ram #(
    parameter int    DATA_LEN   = 32,
    parameter int    DEPTH_LOG2 = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [DEPTH_LOG2-1:0]   rd_addr,
    output logic [DATA_LEN-1:0]     rd_data,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   wr_addr,
    input  logic [DATA_LEN-1:0]     wr_data,
    input  logic [DATA_LEN/8-1:0]   wr_strb
);

    localparam int STRB_LEN = DATA_LEN / 8;

    logic [DATA_LEN-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_LEN; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Non-blocking read of the array gives old data when a write lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_sram_lat.sv
// AXI4-Lite SRAM slave with independent read/write paths, programmable latency
// and SLVERR responses for addresses outside the mapped window.
module axi_sram_lat
    import axi_sram_pkg::*;
#(
    parameter int                  DATA_LEN   = 32,
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DEPTH_LOG2 = 12,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                  RD_LAT     = 1,
    parameter int                  WR_LAT     = 1,
    parameter string               INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_LEN-1:0]     waddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_LEN-1:0]     wdata,
    input  logic [DATA_LEN/8-1:0]   wstrob,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_LEN-1:0]     raddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_LEN-1:0]     rdata,
    output logic [1:0]              rresp
);

    localparam int   STRB_LEN  = DATA_LEN / 8;
    localparam int   OFF_BITS  = $clog2(STRB_LEN);
    localparam int   SPAN_BITS = OFF_BITS + DEPTH_LOG2;
    localparam logic W_DIRECT  = (WR_LAT == 1);
    localparam logic R_DIRECT  = (RD_LAT == 1);

    function automatic logic in_range(input logic [ADDR_LEN-1:0] addr);
        logic [ADDR_LEN-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((offset >> SPAN_BITS) == '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [ADDR_LEN-1:0] addr);
        return DEPTH_LOG2'((addr - BASE_ADDR) >> OFF_BITS);
    endfunction

    w_state_t              w_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_LEN-1:0]   aw_addr_q;
    logic [DATA_LEN-1:0]   w_data_q;
    logic [STRB_LEN-1:0]   w_strb_q;
    logic [CNT_W-1:0]      w_cnt;

    r_state_t              r_state;
    logic [ADDR_LEN-1:0]   ar_addr_q;
    logic [CNT_W-1:0]      r_cnt;

    logic                  aw_take;
    logic                  w_take;
    logic                  aw_now;
    logic                  w_now;
    logic                  w_both;
    logic [ADDR_LEN-1:0]   eff_waddr;
    logic [DATA_LEN-1:0]   eff_wdata;
    logic [STRB_LEN-1:0]   eff_wstrb;
    logic                  w_ok;
    logic                  w_commit;
    logic                  ram_we;

    logic [ADDR_LEN-1:0]   eff_raddr;
    logic                  r_ok;
    logic                  r_sample;
    logic                  ram_re;
    logic [DATA_LEN-1:0]   ram_q;

    // A handshake in this cycle is folded in so WR_LAT=1 can commit on the accepting edge.
    assign aw_take   = awvalid && awready;
    assign w_take    = wvalid && wready;
    assign aw_now    = aw_held || aw_take;
    assign w_now     = w_held || w_take;
    assign w_both    = aw_now && w_now;
    assign eff_waddr = aw_held ? aw_addr_q : waddr;
    assign eff_wdata = w_held ? w_data_q : wdata;
    assign eff_wstrb = w_held ? w_strb_q : wstrob;
    assign w_ok      = in_range(eff_waddr);
    assign w_commit  = ((w_state == W_IDLE) && w_both && W_DIRECT) ||
                       ((w_state == W_WAIT) && (w_cnt == CNT_W'(1)));
    assign ram_we    = w_commit && w_ok && !rst;

    assign eff_raddr = (r_state == R_IDLE) ? raddr : ar_addr_q;
    assign r_ok      = in_range(eff_raddr);
    assign r_sample  = ((r_state == R_IDLE) && arvalid && arready && R_DIRECT) ||
                       ((r_state == R_WAIT) && (r_cnt == CNT_W'(1)));
    assign ram_re    = r_sample && r_ok;

    assign rdata = (rresp == RESP_SLVERR) ? '0 : ram_q;

    axi_sram_lat_ram #(
        .DATA_LEN   (DATA_LEN),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (ram_re),
        .rd_addr (word_index(eff_raddr)),
        .rd_data (ram_q),
        .wr_en   (ram_we),
        .wr_addr (word_index(eff_waddr)),
        .wr_data (eff_wdata),
        .wr_strb (eff_wstrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_cnt     <= '0;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_take) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= waddr;
                    end
                    if (w_take) begin
                        w_held   <= 1'b1;
                        w_data_q <= wdata;
                        w_strb_q <= wstrob;
                    end
                    if (w_both) begin
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        if (W_DIRECT) begin
                            bvalid  <= 1'b1;
                            bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt   <= CNT_W'(WR_LAT - 1);
                            w_state <= W_WAIT;
                        end
                    end else begin
                        awready <= !aw_now;
                        wready  <= !w_now;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == CNT_W'(1)) begin
                        bvalid  <= 1'b1;
                        bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rresp also selects whether rdata shows the sampled word or zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            ar_addr_q <= '0;
            r_cnt     <= '0;
            arready   <= 1'b1;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready   <= 1'b0;
                        ar_addr_q <= raddr;
                        if (R_DIRECT) begin
                            rvalid  <= 1'b1;
                            rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
                            r_state <= R_RESP;
                        end else begin
                            r_cnt   <= CNT_W'(RD_LAT - 1);
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        rvalid  <= 1'b1;
                        rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_lat.sv
// Self-checking bench for axi_sram_lat: directed vector table, multi-cycle corner
// sequences and a randomized phase checked against a word-array reference model.
module tb_axi_sram_lat;

    localparam int          RD_LAT = 3;
    localparam int          WR_LAT = 2;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] LIMIT  = 32'h8000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] waddr, wdata, raddr, rdata;
    logic [3:0]  wstrob;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] ref_mem [int];

    axi_sram_lat #(
        .DATA_LEN   (32),
        .ADDR_LEN   (32),
        .DEPTH_LOG2 (12),
        .BASE_ADDR  (32'h8000_0000),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT),
        .INIT_FILE  ("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awvalid (awvalid),
        .awready (awready),
        .waddr   (waddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrob  (wstrob),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .raddr   (raddr),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: DUT did not respond within the cycle bound", name);
    endtask

    function automatic bit addr_ok(input logic [31:0] addr);
        return (addr >= BASE) && (addr < LIMIT);
    endfunction

    function automatic int addr_key(input logic [31:0] addr);
        return int'((addr - BASE) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
        logic [31:0] r;
        logic [31:0] mask;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            mask = 32'hFF << (8 * b);
            if (strb[b]) r = (r & ~mask) | (new_w & mask);
        end
        return r;
    endfunction

    function automatic logic [40:0] out_vec();
        return {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata};
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int stall,
                            output logic [1:0] resp, output int lat, output int hold_err, output int stall_err);
        int t;
        bit aw_done, w_done;
        t = 0; aw_done = 0; w_done = 0;
        hold_err = 0; stall_err = 0; lat = 0; resp = 2'b11;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if (w_done && wready) hold_err++;
            if (aw_done && awready) hold_err++;
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            waddr = addr; wdata = data; wstrob = strb;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            t++;
            if (t > 100) begin
                timeout_fail("write address/data handshake");
                awvalid = 0; wvalid = 0;
                return;
            end
        end
        do begin
            @(negedge clk);
            awvalid = 0; wvalid = 0;
            lat++;
        end while (!bvalid && lat < 300);
        if (!bvalid) begin
            timeout_fail("write response");
            return;
        end
        resp = bresp;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!bvalid || bresp !== resp || awready || wready) stall_err++;
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        if (bvalid || !awready || !wready) stall_err++;
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall,
                           output logic [31:0] data, output logic [1:0] resp, output int lat, output int stall_err);
        int t;
        t = 0; lat = 0; stall_err = 0; data = 'x; resp = 2'b11;
        @(negedge clk);
        arvalid = 1; raddr = addr;
        while (!arready) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                timeout_fail("read address handshake");
                arvalid = 0;
                return;
            end
        end
        do begin
            @(negedge clk);
            arvalid = 0;
            lat++;
            if (!rvalid && arready) stall_err++;
        end while (!rvalid && lat < 300);
        if (!rvalid) begin
            timeout_fail("read response");
            return;
        end
        data = rdata;
        resp = rresp;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!rvalid || rdata !== data || rresp !== resp || arready) stall_err++;
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        if (rvalid || !arready) stall_err++;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [1:0]  resp;
        logic [31:0] data;
        int lat, e_hold, e_stall;
        string tag;
        if (v.wr) begin
            tag = $sformatf("vec%0d write", idx);
            do_write(v.addr, v.data, v.strb, 0, 0, 0, resp, lat, e_hold, e_stall);
            checkOutput({tag, " bresp"}, 64'(resp), 64'(v.exp_resp));
            checkOutput({tag, " latency"}, 64'(lat), 64'(WR_LAT));
            checkOutput({tag, " handshake"}, 64'(e_stall), 64'(0));
        end else begin
            tag = $sformatf("vec%0d read", idx);
            do_read(v.addr, 0, data, resp, lat, e_stall);
            checkOutput({tag, " rresp"}, 64'(resp), 64'(v.exp_resp));
            checkOutput({tag, " rdata"}, 64'(data), 64'(v.exp_data));
            checkOutput({tag, " latency"}, 64'(lat), 64'(RD_LAT));
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data, addr, exp_d;
        logic [3:0]  strb;
        int lat, e_hold, e_stall, viol, sel;

        rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        waddr = '0; wdata = '0; wstrob = '0; raddr = '0;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vecs[3]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'h5, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'hFF22_FF44, 2'b00};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         2'b00};
        vecs[6]  = '{1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b00};
        vecs[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[9]  = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[10] = '{1'b1, 32'h8000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0,         2'b00};
        vecs[11] = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 2'b00};
        vecs[12] = '{1'b1, 32'h8000_0020, 32'h0,         4'h0, 32'h0,         2'b00};
        vecs[13] = '{1'b0, 32'h8000_0023, 32'h0,         4'h0, 32'hFF22_FF44, 2'b00};
        vecs[14] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 32'h0,         2'b10};
        vecs[15] = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 2'b00};

        repeat (2) @(negedge clk);
        checkOutput("outputs during reset", 64'(out_vec()), 64'({3'b111, 2'b00, 4'b0000, 32'h0}));
        rst = 0;
        @(negedge clk);
        checkOutput("outputs after reset", 64'(out_vec()), 64'({3'b111, 2'b00, 4'b0000, 32'h0}));

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

        $display("[TB] W ahead of AW by two cycles");
        do_write(32'h8000_0040, 32'hCAFE_F00D, 4'hF, 2, 0, 0, resp, lat, e_hold, e_stall);
        checkOutput("w-first latency", 64'(lat), 64'(WR_LAT));
        checkOutput("w-first wready held low", 64'(e_hold), 64'(0));
        checkOutput("w-first bresp", 64'(resp), 64'(0));
        do_write(32'h8000_0044, 32'h0102_0304, 4'hF, 0, 3, 0, resp, lat, e_hold, e_stall);
        checkOutput("aw-first latency", 64'(lat), 64'(WR_LAT));
        checkOutput("aw-first awready held low", 64'(e_hold), 64'(0));
        do_read(32'h8000_0040, 0, data, resp, lat, e_stall);
        checkOutput("w-first readback", 64'(data), 64'(32'hCAFE_F00D));
        do_read(32'h8000_0044, 0, data, resp, lat, e_stall);
        checkOutput("aw-first readback", 64'(data), 64'(32'h0102_0304));

        $display("[TB] bready/rready held low");
        do_write(32'h8000_0050, 32'h7777_8888, 4'hF, 0, 0, 5, resp, lat, e_hold, e_stall);
        checkOutput("b stall stability", 64'(e_stall), 64'(0));
        do_read(32'h8000_0050, 5, data, resp, lat, e_stall);
        checkOutput("r stall stability", 64'(e_stall), 64'(0));
        checkOutput("r stall rdata", 64'(data), 64'(32'h7777_8888));
        do_read(32'h8000_4010, 5, data, resp, lat, e_stall);
        checkOutput("r stall slverr stability", 64'(e_stall), 64'(0));
        checkOutput("r stall slverr rresp", 64'(resp), 64'(2'b10));

        $display("[TB] reset during pending read and write");
        @(negedge clk);
        awvalid = 1; wvalid = 1; waddr = 32'h8000_0010; wdata = 32'h0; wstrob = 4'hF;
        arvalid = 1; raddr = 32'h8000_0020;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        checkOutput("busy before reset", 64'({awready, wready, arready}), 64'(3'b000));
        #1 rst = 1;
        #1 checkOutput("async reset outputs", 64'(out_vec()), 64'({3'b111, 2'b00, 4'b0000, 32'h0}));
        @(negedge clk);
        rst = 0;
        checkOutput("outputs after mid-transaction reset", 64'(out_vec()), 64'({3'b111, 2'b00, 4'b0000, 32'h0}));
        viol = 0;
        repeat (4) begin
            @(negedge clk);
            if (bvalid || rvalid) viol++;
        end
        checkOutput("no stray response after reset", 64'(viol), 64'(0));
        do_read(32'h8000_0010, 0, data, resp, lat, e_stall);
        checkOutput("discarded write left data", 64'(data), 64'(32'hDEAD_BEEF));
        do_read(32'h8000_0020, 0, data, resp, lat, e_stall);
        checkOutput("fresh read after reset", 64'(data), 64'(32'hFF22_FF44));

        $display("[TB] randomized traffic against reference model");
        for (int k = 0; k < 16; k++) begin
            addr = 32'h8000_1000 + 32'(4 * k);
            data = $urandom;
            ref_mem[addr_key(addr)] = data;
            do_write(addr, data, 4'hF, 0, 0, 0, resp, lat, e_hold, e_stall);
            checkOutput($sformatf("rand init %0d bresp", k), 64'(resp), 64'(0));
        end
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 16)      addr = 32'h8000_1000 + 32'(4 * sel) + 32'($urandom_range(0, 3));
            else if (sel < 18) addr = LIMIT + 32'(4 * $urandom_range(0, 1023));
            else               addr = BASE - 32'd4 - 32'(4 * $urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)), resp, lat, e_hold, e_stall);
                if (addr_ok(addr)) ref_mem[addr_key(addr)] = merge(ref_mem[addr_key(addr)], data, strb);
                checkOutput($sformatf("rand %0d write bresp @%h", i, addr), 64'(resp), addr_ok(addr) ? 64'(0) : 64'(2));
                checkOutput($sformatf("rand %0d write latency", i), 64'(lat), 64'(WR_LAT));
                checkOutput($sformatf("rand %0d write handshake", i), 64'(e_hold + e_stall), 64'(0));
            end else begin
                do_read(addr, int'($urandom_range(0, 2)), data, resp, lat, e_stall);
                exp_d = addr_ok(addr) ? ref_mem[addr_key(addr)] : 32'h0;
                checkOutput($sformatf("rand %0d read rdata @%h", i, addr), 64'(data), 64'(exp_d));
                checkOutput($sformatf("rand %0d read rresp", i), 64'(resp), addr_ok(addr) ? 64'(0) : 64'(2));
                checkOutput($sformatf("rand %0d read latency", i), 64'(lat), 64'(RD_LAT));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
